// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: the pipeline control word, store widths and FSM states.
// Also the alignment rule shared by the incoming-op check and the latched store aligner.
package mem_stage_pkg;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [1:0] wb_sel;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
    } rv32i_control_word;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    // funct3[1:0] gives the access size for both loads (incl. LBU/LHU) and stores.
    function automatic logic access_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
        logic result;
        case (funct3[1:0])
            2'b00:   result = 1'b0;
            2'b01:   result = addr[0];
            default: result = |addr;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/mem_stage_store_align.sv
// Combinational store lane steering: byte enables, replicated write data and alignment flag.
module mem_stage_store_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_rs2,
    output logic [3:0]  o_wmask,
    output logic [31:0] o_wdata,
    output logic        o_misaligned
);

    store_funct3_t w_width;

    assign w_width = store_funct3_t'({1'b0, i_funct3[1:0]});

    always_comb begin
        o_wmask = 4'b1111;
        o_wdata = i_rs2;
        case (w_width)
            SB: begin
                o_wmask = 4'b0001 << i_addr;
                o_wdata = {4{i_rs2[7:0]}};
            end
            SH: begin
                o_wmask = i_addr[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_rs2[15:0]}};
            end
            default: ;
        endcase
    end

    assign o_misaligned = access_misaligned(i_funct3, i_addr);

endmodule

// File: rtl/register.sv
// Loadable pipeline register with asynchronous active-low clear.
module register #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mem_stage.sv
// EX/MEM pipeline latch plus data-memory access controller; stalls the pipe until dmem responds
// and captures load data for WB.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [31:0]       i_pc,
    input  logic [31:0]       i_pc_plus4,
    input  logic [31:0]       i_alu,
    input  logic [31:0]       i_rs2,
    input  logic [31:0]       i_u_imm,
    input  logic [31:0]       i_ir,
    input  logic [4:0]        i_rd_addr,
    input  logic [4:0]        i_rs1_addr,
    input  logic [4:0]        i_rs2_addr,
    input  rv32i_control_word i_control_rom,
    input  logic              i_dmem_resp,
    input  logic [31:0]       i_dmem_rdata,
    output logic              o_dmem_read,
    output logic              o_dmem_write,
    output logic [31:0]       o_dmem_address,
    output logic [3:0]        o_dmem_wmask,
    output logic [31:0]       o_dmem_wdata,
    output logic [31:0]       o_pc,
    output logic [31:0]       o_pc_plus4,
    output logic [31:0]       o_alu,
    output logic [31:0]       o_rs2,
    output logic [31:0]       o_u_imm,
    output logic [31:0]       o_ir,
    output logic [4:0]        o_rd_addr,
    output logic [4:0]        o_rs1_addr,
    output logic [4:0]        o_rs2_addr,
    output rv32i_control_word o_control_rom,
    output logic [31:0]       o_mdr,
    output logic              o_stall_mem,
    output logic              o_misaligned,
    output logic              o_mem_timeout
);

    localparam int CW_W = $bits(rv32i_control_word);
    localparam logic [31:0] LP_LAST_WAIT = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

    mem_state_t        r_state;
    mem_state_t        w_state_next;
    logic              w_adv;
    logic              w_stall;
    logic              w_req_read;
    logic              w_req_write;
    logic              w_new_mem_op;
    logic [CW_W-1:0]   w_ctrl_bits;
    rv32i_control_word w_ctrl;
    logic [3:0]        w_wmask;
    logic              w_sa_misaligned;
    logic [31:0]       r_mdr;
    logic [31:0]       r_wait_cnt;
    logic              r_timeout;
    logic              w_timeout_hit;

    // The latch only advances when this stage is not itself holding the pipe.
    register #(.WIDTH(32)) u_pc_reg       (.clk(clk), .rst_n(rst_n), .i_load(w_adv), .i_d(i_pc),       .o_q(o_pc));
    register #(.WIDTH(32)) u_pc_plus4_reg (.clk(clk), .rst_n(rst_n), .i_load(w_adv), .i_d(i_pc_plus4), .o_q(o_pc_plus4));
    register #(.WIDTH(32)) u_alu_reg      (.clk(clk), .rst_n(rst_n), .i_load(w_adv), .i_d(i_alu),      .o_q(o_alu));
    register #(.WIDTH(32)) u_rs2_reg      (.clk(clk), .rst_n(rst_n), .i_load(w_adv), .i_d(i_rs2),      .o_q(o_rs2));
    register #(.WIDTH(32)) u_u_imm_reg    (.clk(clk), .rst_n(rst_n), .i_load(w_adv), .i_d(i_u_imm),    .o_q(o_u_imm));
    register #(.WIDTH(32)) u_ir_reg       (.clk(clk), .rst_n(rst_n), .i_load(w_adv), .i_d(i_ir),       .o_q(o_ir));
    register #(.WIDTH(5))  u_rd_reg       (.clk(clk), .rst_n(rst_n), .i_load(w_adv), .i_d(i_rd_addr),  .o_q(o_rd_addr));
    register #(.WIDTH(5))  u_rs1_reg      (.clk(clk), .rst_n(rst_n), .i_load(w_adv), .i_d(i_rs1_addr), .o_q(o_rs1_addr));
    register #(.WIDTH(5))  u_rs2a_reg     (.clk(clk), .rst_n(rst_n), .i_load(w_adv), .i_d(i_rs2_addr), .o_q(o_rs2_addr));
    register #(.WIDTH(CW_W)) u_ctrl_reg   (.clk(clk), .rst_n(rst_n), .i_load(w_adv), .i_d(i_control_rom), .o_q(w_ctrl_bits));

    assign w_ctrl        = rv32i_control_word'(w_ctrl_bits);
    assign o_control_rom = w_ctrl;

    mem_stage_store_align u_store_align (
        .i_funct3     (o_ir[14:12]),
        .i_addr       (o_alu[1:0]),
        .i_rs2        (o_rs2),
        .o_wmask      (w_wmask),
        .o_wdata      (o_dmem_wdata),
        .o_misaligned (w_sa_misaligned)
    );

    assign w_new_mem_op = (i_control_rom.mem_read | i_control_rom.mem_write)
                        & ~access_misaligned(i_ir[14:12], i_alu[1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_req_read   = 1'b0;
        w_req_write  = 1'b0;
        case (r_state)
            ACCESS: begin
                w_req_read  = w_ctrl.mem_read;
                w_req_write = w_ctrl.mem_write;
                w_stall     = ~i_dmem_resp;
                if (i_dmem_resp && !i_load) begin
                    w_state_next = DONE;
                end
            end
            default: ;
        endcase
        w_adv = i_load & ~w_stall;
        if (w_adv) begin
            w_state_next = w_new_mem_op ? ACCESS : IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mdr <= '0;
        end else if (r_state == ACCESS && i_dmem_resp) begin
            r_mdr <= i_dmem_rdata;
        end
    end

    // Wait counter restarts with every new latch; saturates rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_adv) begin
                r_wait_cnt <= '0;
            end else if (r_state == ACCESS && !i_dmem_resp && r_wait_cnt != '1) begin
                r_wait_cnt <= r_wait_cnt + 32'd1;
            end
            if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (r_state == ACCESS) && !i_dmem_resp
                         && (r_wait_cnt == LP_LAST_WAIT);

    assign o_dmem_read    = w_req_read;
    assign o_dmem_write   = w_req_write;
    assign o_dmem_address = {o_alu[31:2], 2'b00};
    assign o_dmem_wmask   = w_req_write ? w_wmask : 4'b0000;
    assign o_mdr          = (r_state == ACCESS && i_dmem_resp) ? i_dmem_rdata : r_mdr;
    assign o_stall_mem    = w_stall;
    assign o_misaligned   = (w_ctrl.mem_read | w_ctrl.mem_write) & w_sa_misaligned;
    assign o_mem_timeout  = r_timeout | w_timeout_hit;

endmodule
